sodor_mem_host_port: RTL

//  - Host-side initiator for the async-read scratchpad's host write port (hw_*) and host read port (hr_*).
//  - Turns single-beat host commands (program load, memory peek/poke) into one-cycle masked writes or reads.
//  - Returns one response per command over a valid/ready channel.
//  - Sits between the simulator/loader bridge and the scratchpad.

---
 rtl/sodor_mem_pkg.sv | 56 +++++
 rtl/sodor_mem_host_port.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sodor_mem_pkg.sv
// Package: sodor_mem_pkg
// Shared types and helpers for the scratchpad host port.
//   size_e        : access size encoding carried on cmd_size.
//   state_e       : host port FSM states. VERIFY exists only when
//                   SODOR_HOST_WRITE_VERIFY_EN is defined.
//   size_to_mask  : byte-lane enable pattern for an access size.
//   size_to_bytes : number of bytes covered by an access size.
package sodor_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

`ifdef SODOR_HOST_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    VERIFY = 3'd3,
    RESP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RESP  = 3'd4
  } state_e;
`endif

  // (1 << (1 << size)) - 1 for the legal sizes. The illegal size is
  // rejected before any lane is used, so it maps to no lanes at all.
  function automatic logic [3:0] size_to_mask(input size_e size);
    case (size)
      SZ_B:    return 4'h1;
      SZ_H:    return 4'h3;
      SZ_W:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // 1 << size; the illegal size still reports 8 so the bounds check
  // stays meaningful even though the size alone already errors.
  function automatic logic [3:0] size_to_bytes(input size_e size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sodor_mem_host_port.sv
// Module: sodor_mem_host_port
// Host-side initiator for the async-read scratchpad. Each accepted
// single-beat command becomes one masked write strobe (hw_*) or one
// read cycle (hr_*), followed by exactly one response on rsp_*.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_write, cmd_size     1=write/0=read; 0=byte 1=half 2=word 3=illegal
//   cmd_addr, cmd_wdata     byte address (any alignment), low-aligned data
//   rsp_valid/rsp_ready     response handshake, held until consumed
//   rsp_data, rsp_err       zero-extended read data (0 for writes), error
//   hw_addr/data/mask/en    scratchpad write port (en high for one cycle)
//   hr_addr, hr_data        scratchpad combinational read port
//
// Build option: define SODOR_HOST_WRITE_VERIFY_EN to read back every
// write one cycle later and flag a lane mismatch in rsp_err.
module sodor_mem_host_port
  import sodor_mem_pkg::*;
#(
  parameter int  NUM_BYTES  = (1 << 21),
  parameter int  DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_BYTES),
  localparam int MASK_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_size,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask,
  output logic                  hw_en,
  output logic [ADDR_WIDTH-1:0] hr_addr,
  input  logic [DATA_WIDTH-1:0] hr_data
);

  state_e                state_q, state_d;
  size_e                 size_q, size_d;
  logic                  hw_en_q, hw_en_d;
  logic [ADDR_WIDTH-1:0] hw_addr_q, hw_addr_d;
  logic [DATA_WIDTH-1:0] hw_data_q, hw_data_d;
  logic [MASK_WIDTH-1:0] hw_mask_q, hw_mask_d;
  logic [ADDR_WIDTH-1:0] hr_addr_q, hr_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef SODOR_HOST_WRITE_VERIFY_EN
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`endif

  // Decode of the incoming command.
  size_e                 cmd_size_e;
  logic [MASK_WIDTH-1:0] cmd_lanes;
  logic [ADDR_WIDTH:0]   cmd_end;
  logic                  cmd_bad;

  assign cmd_size_e = size_e'(cmd_size);
  assign cmd_lanes  = MASK_WIDTH'(size_to_mask(cmd_size_e));
  // One extra bit so addr + bytes cannot wrap back into range.
  assign cmd_end    = {1'b0, cmd_addr} + (ADDR_WIDTH + 1)'(size_to_bytes(cmd_size_e));
  assign cmd_bad    = (cmd_size_e == SZ_BAD) || (cmd_end > (ADDR_WIDTH + 1)'(NUM_BYTES));

  // Bit-level mask for the latched size, used to zero-extend read data.
  logic [MASK_WIDTH-1:0] hold_lanes;
  logic [DATA_WIDTH-1:0] hold_dmask;

  assign hold_lanes = MASK_WIDTH'(size_to_mask(size_q));
  for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_dmask
    assign hold_dmask[8*gi +: 8] = {8{hold_lanes[gi]}};
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    hw_en_d     = 1'b0;
    hw_addr_d   = '0;
    hw_data_d   = '0;
    hw_mask_d   = '0;
    hr_addr_d   = hr_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef SODOR_HOST_WRITE_VERIFY_EN
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          size_d = cmd_size_e;
          if (cmd_bad) begin
            // Rejected commands never reach the memory ports.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else if (cmd_write) begin
            // Write strobe is registered so it is high exactly in WRITE.
            state_d   = WRITE;
            hw_en_d   = 1'b1;
            hw_addr_d = cmd_addr;
            hw_data_d = cmd_wdata;
            hw_mask_d = cmd_lanes;
`ifdef SODOR_HOST_WRITE_VERIFY_EN
            addr_d    = cmd_addr;
            wdata_d   = cmd_wdata;
`endif
          end else begin
            state_d   = READ;
            hr_addr_d = cmd_addr;
          end
        end
      end

      WRITE: begin
`ifdef SODOR_HOST_WRITE_VERIFY_EN
        state_d   = VERIFY;
        hr_addr_d = addr_q;
`else
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
`endif
      end

      READ: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = hr_data & hold_dmask;
      end

`ifdef SODOR_HOST_WRITE_VERIFY_EN
      VERIFY: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        // Only the written lanes take part in the comparison.
        if (((hr_data ^ wdata_q) & hold_dmask) != '0) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = hr_data & hold_dmask;
        end else begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
        end
      end
`endif

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_q      <= SZ_B;
      hw_en_q     <= 1'b0;
      hw_addr_q   <= '0;
      hw_data_q   <= '0;
      hw_mask_q   <= '0;
      hr_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SODOR_HOST_WRITE_VERIFY_EN
      addr_q      <= '0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      hw_en_q     <= hw_en_d;
      hw_addr_q   <= hw_addr_d;
      hw_data_q   <= hw_data_d;
      hw_mask_q   <= hw_mask_d;
      hr_addr_q   <= hr_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef SODOR_HOST_WRITE_VERIFY_EN
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign hw_en     = hw_en_q;
  assign hw_addr   = hw_addr_q;
  assign hw_data   = hw_data_q;
  assign hw_mask   = hw_mask_q;
  assign hr_addr   = hr_addr_q;

endmodule
